// File: rtl/npc_pkg.sv
// Shared NPC core constants and types used by the IDU register file.
package npc_pkg;

  localparam int REG_W   = 32;
  localparam int NREG    = 32;
  localparam int SB_AW   = $clog2(NREG);
  localparam int SB_TAGW = 4;

  typedef logic [SB_AW-1:0]   reg_addr_t;
  typedef logic [SB_TAGW-1:0] sb_tag_t;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: zero register, write bypass (highest write port wins), then stored value.
module regfile_sb_rdport
  import npc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int NWR   = 1,
  parameter int TAGW  = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]        rd_addr,
  input  logic [NREG*WIDTH-1:0] rf_flat,
  input  logic [NREG-1:0]      busy_vec,
  input  logic [NREG*TAGW-1:0] tag_flat,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NWR*TAGW-1:0]  wr_tag,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_busy
);

  logic [TAGW-1:0] cur_tag;
  logic            cur_busy;

  assign cur_tag  = tag_flat[32'(rd_addr)*TAGW +: TAGW];
  assign cur_busy = busy_vec[rd_addr];

  always_comb begin
    rd_data = rf_flat[32'(rd_addr)*WIDTH +: WIDTH];
    rd_busy = cur_busy;
    // Ascending loop so the highest-index hitting port ends up selected.
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && wr_addr[p*AW +: AW] == rd_addr) begin
        rd_data = wr_data[p*WIDTH +: WIDTH];
        rd_busy = cur_busy && (cur_tag != wr_tag[p*TAGW +: TAGW]);
      end
    end
    if (rd_addr == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with per-register busy/tag scoreboard for RAW/WAW tracking.
module regfile_sb #(
  parameter int WIDTH = npc_pkg::REG_W,
  parameter int NREG  = npc_pkg::NREG,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int TAGW  = npc_pkg::SB_TAGW,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  input  logic [TAGW-1:0]       iss_tag,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*WIDTH-1:0]  wr_data,
  input  logic [NWR*TAGW-1:0]   wr_tag,
  input  logic                  flush,
  output logic [NREG*WIDTH-1:0] dbg_regs
);

  logic [NREG*WIDTH-1:0] rf_flat;
  logic [NREG-1:0]       busy_vec;
  logic [NREG*TAGW-1:0]  tag_flat;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign rf_flat[0 +: WIDTH] = '0;
      assign busy_vec[0]         = 1'b0;
      assign tag_flat[0 +: TAGW] = '0;
    end else begin : g_live
      logic [WIDTH-1:0] rf_q, rf_d;
      logic             busy_q, busy_d;
      logic [TAGW-1:0]  tag_q, tag_d;

      always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(gi)) begin
            rf_d = wr_data[p*WIDTH +: WIDTH];
            // Only the writer holding the current tag may release the register.
            if (busy_q && tag_q == wr_tag[p*TAGW +: TAGW]) begin
              busy_d = 1'b0;
            end
          end
        end
        if (flush) begin
          busy_d = 1'b0;
        end else if (iss_en && iss_rd == AW'(gi)) begin
          busy_d = 1'b1;
          tag_d  = iss_tag;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rf_q   <= '0;
          busy_q <= 1'b0;
          tag_q  <= '0;
        end else begin
          rf_q   <= rf_d;
          busy_q <= busy_d;
          tag_q  <= tag_d;
        end
      end

      assign rf_flat[gi*WIDTH +: WIDTH] = rf_q;
      assign busy_vec[gi]               = busy_q;
      assign tag_flat[gi*TAGW +: TAGW]  = tag_q;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    regfile_sb_rdport #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .NWR   (NWR),
      .TAGW  (TAGW)
    ) u_rdport (
      .rd_addr  (rd_addr[gi*AW +: AW]),
      .rf_flat  (rf_flat),
      .busy_vec (busy_vec),
      .tag_flat (tag_flat),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_tag   (wr_tag),
      .rd_data  (rd_data[gi*WIDTH +: WIDTH]),
      .rd_busy  (rd_busy[gi])
    );
  end

  assign dbg_regs = rf_flat;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed scoreboard bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  import npc_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int TAGW  = 4;
  localparam int AW    = $clog2(NREG);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*WIDTH-1:0]  rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic [TAGW-1:0]       iss_tag;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*WIDTH-1:0]  wr_data;
  logic [NWR*TAGW-1:0]   wr_tag;
  logic                  flush;
  logic [NREG*WIDTH-1:0] dbg_regs;

  regfile_sb #(.WIDTH(WIDTH), .NREG(NREG), .NRD(NRD), .NWR(NWR), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_tag(iss_tag), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_tag(wr_tag), .flush(flush), .dbg_regs(dbg_regs)
  );

  always #5 clk = ~clk;

  // Reference architectural state
  logic [WIDTH-1:0] m_rf   [NREG];
  bit               m_busy [NREG];
  logic [TAGW-1:0]  m_tag  [NREG];

  // Stimulus for the current cycle
  int               s_rd [NRD];
  bit               s_we [NWR];
  int               s_wa [NWR];
  logic [WIDTH-1:0] s_wd [NWR];
  logic [TAGW-1:0]  s_wt [NWR];
  bit               s_ie;
  int               s_ir;
  logic [TAGW-1:0]  s_it;
  bit               s_fl;

  typedef struct {
    int               kind;   // 0 = read port, 1 = debug register view
    int               idx;
    logic [WIDTH-1:0] data;
    bit               busy;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic clear_stim();
    for (int i = 0; i < NRD; i++) s_rd[i] = 0;
    for (int p = 0; p < NWR; p++) begin
      s_we[p] = 0; s_wa[p] = 0; s_wd[p] = '0; s_wt[p] = '0;
    end
    s_ie = 0; s_ir = 0; s_it = '0; s_fl = 0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_rf[r] = '0; m_busy[r] = 0; m_tag[r] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'(s_rd[i]);
    for (int p = 0; p < NWR; p++) begin
      wr_en[p]                 = s_we[p];
      wr_addr[p*AW +: AW]      = AW'(s_wa[p]);
      wr_data[p*WIDTH +: WIDTH] = s_wd[p];
      wr_tag[p*TAGW +: TAGW]   = s_wt[p];
    end
    iss_en  = s_ie;
    iss_rd  = AW'(s_ir);
    iss_tag = s_it;
    flush   = s_fl;
  endtask

  // Value/busy a reader should observe this cycle, given model state and in-flight writes.
  task automatic expect_read(input int a, output logic [WIDTH-1:0] d, output bit b);
    int win;
    win = -1;
    for (int p = 0; p < NWR; p++) if (s_we[p] && s_wa[p] == a) win = p;
    if (a == 0) begin
      d = '0; b = 0;
    end else if (win >= 0) begin
      d = s_wd[win];
      b = m_busy[a] && (m_tag[a] != s_wt[win]);
    end else begin
      d = m_rf[a]; b = m_busy[a];
    end
  endtask

  task automatic commit();
    bit nb [NREG];
    nb = m_busy;
    for (int p = 0; p < NWR; p++) begin
      if (s_we[p] && s_wa[p] != 0) begin
        m_rf[s_wa[p]] = s_wd[p];
        if (m_busy[s_wa[p]] && m_tag[s_wa[p]] == s_wt[p]) nb[s_wa[p]] = 0;
      end
    end
    if (s_fl) begin
      for (int r = 0; r < NREG; r++) nb[r] = 0;
    end else if (s_ie && s_ir != 0) begin
      nb[s_ir] = 1;
      m_tag[s_ir] = s_it;
    end
    m_busy = nb;
  endtask

  task automatic push_reads(input string nm);
    exp_t e;
    for (int i = 0; i < NRD; i++) begin
      e.kind = 0; e.idx = i; e.name = nm;
      expect_read(s_rd[i], e.data, e.busy);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_dbg(input string nm);
    exp_t e;
    for (int r = 0; r < NREG; r++) begin
      e.kind = 1; e.idx = r; e.name = nm; e.data = m_rf[r]; e.busy = 0;
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input string nm, input bit dbg);
    drive();
    push_reads(nm);
    if (dbg) push_dbg(nm);
    $display("cycle %0d %s rd=%0d/%0d we=%0d/%0d wa=%0d/%0d iss=%0d x%0d t%0d flush=%0d",
             cyc, nm, s_rd[0], s_rd[1], s_we[0], s_we[1], s_wa[0], s_wa[1], s_ie, s_ir, s_it, s_fl);
    @(negedge clk);
    @(posedge clk);
    if (rst_n) commit();
    cyc++;
    #1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic reset_mid(input string nm);
    #1;
    rst_n = 1'b0;
    model_reset();
    clear_stim();
    s_rd[0] = 5; s_rd[1] = 3;
    drive();
    push_reads(nm);
    push_dbg(nm);
    $display("cycle %0d %s async reset", cyc, nm);
    @(negedge clk);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (mon_e.kind == 0) begin
        if (rd_data[mon_e.idx*WIDTH +: WIDTH] !== mon_e.data || rd_busy[mon_e.idx] !== mon_e.busy) begin
          bad++;
          $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%0d", mon_e.name,
                   mon_e.idx, rd_data[mon_e.idx*WIDTH +: WIDTH], rd_busy[mon_e.idx], mon_e.data, mon_e.busy);
        end
      end else begin
        if (dbg_regs[mon_e.idx*WIDTH +: WIDTH] !== mon_e.data) begin
          bad++;
          $display("FAIL %s dbg_x%0d: got %h, want %h", mon_e.name, mon_e.idx,
                   dbg_regs[mon_e.idx*WIDTH +: WIDTH], mon_e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    clear_stim();
    s_rd[0] = 1; s_rd[1] = 31;
    drive();
    push_reads("por");
    push_dbg("por");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: async reset mid-operation
    clear_stim();
    s_we[0] = 1; s_wa[0] = 5; s_wd[0] = 32'h1234; s_ie = 1; s_ir = 5; s_it = 4'd1; s_rd[0] = 5;
    step("t1_write", 0);
    clear_stim(); s_rd[0] = 5; s_rd[1] = 5;
    step("t1_before", 0);
    reset_mid("t1_reset");
    clear_stim(); s_rd[0] = 5; s_rd[1] = 5;
    step("t1_after", 1);

    // 2: same-cycle bypass then stored value
    clear_stim();
    s_we[0] = 1; s_wa[0] = 7; s_wd[0] = 32'hDEADBEEF; s_rd[0] = 7;
    step("t2_bypass", 0);
    clear_stim(); s_rd[0] = 7; s_rd[1] = 7;
    step("t2_held", 0);

    // 3: register zero
    clear_stim();
    s_we[0] = 1; s_wa[0] = 0; s_wd[0] = 32'hFFFF_FFFF; s_we[1] = 1; s_wa[1] = 0; s_wd[1] = 32'hFFFF_FFFF;
    s_ie = 1; s_ir = 0; s_it = 4'd7;
    step("t3_x0_wr", 0);
    clear_stim();
    step("t3_x0_rd", 1);

    // 4: RAW scoreboard
    clear_stim(); s_ie = 1; s_ir = 3; s_it = 4'd2; s_rd[0] = 3;
    step("t4_issue", 0);
    for (int k = 0; k < 3; k++) begin
      clear_stim(); s_rd[0] = 3; s_rd[1] = 3;
      step("t4_wait", 0);
    end
    clear_stim(); s_we[0] = 1; s_wa[0] = 3; s_wt[0] = 4'd2; s_wd[0] = 32'h55; s_rd[0] = 3; s_rd[1] = 3;
    step("t4_wb", 0);
    clear_stim(); s_rd[0] = 3;
    step("t4_done", 0);

    // 5: WAW protection
    clear_stim(); s_ie = 1; s_ir = 9; s_it = 4'd1;
    step("t5_iss1", 0);
    clear_stim(); s_ie = 1; s_ir = 9; s_it = 4'd3; s_rd[0] = 9;
    step("t5_iss3", 0);
    clear_stim(); s_we[1] = 1; s_wa[1] = 9; s_wt[1] = 4'd1; s_wd[1] = 32'hA; s_rd[0] = 9;
    step("t5_stale_wb", 0);
    clear_stim(); s_rd[1] = 9;
    step("t5_still_busy", 0);
    clear_stim(); s_we[0] = 1; s_wa[0] = 9; s_wt[0] = 4'd3; s_wd[0] = 32'hB; s_rd[0] = 9;
    step("t5_wb", 0);
    clear_stim(); s_rd[0] = 9; s_rd[1] = 9;
    step("t5_done", 0);

    // 6: collisions and priorities
    clear_stim();
    s_we[0] = 1; s_wa[0] = 4; s_wd[0] = 32'h11; s_we[1] = 1; s_wa[1] = 4; s_wd[1] = 32'h22;
    s_rd[0] = 4; s_ie = 1; s_ir = 4; s_it = 4'd5;
    step("t6_dual_wr", 0);
    clear_stim();
    s_ie = 1; s_ir = 4; s_it = 4'd6; s_we[0] = 1; s_wa[0] = 4; s_wt[0] = 4'd5; s_wd[0] = 32'h33; s_rd[0] = 4;
    step("t6_iss_vs_clr", 0);
    clear_stim(); s_we[0] = 1; s_wa[0] = 4; s_wt[0] = 4'd5; s_wd[0] = 32'h44; s_rd[0] = 4; s_rd[1] = 2;
    step("t6_old_tag", 0);
    clear_stim(); s_we[1] = 1; s_wa[1] = 4; s_wt[1] = 4'd6; s_wd[1] = 32'h55; s_rd[1] = 4;
    step("t6_new_tag", 0);
    clear_stim(); s_ie = 1; s_ir = 8; s_it = 4'd2;
    step("t6_iss8", 0);
    clear_stim(); s_fl = 1; s_ie = 1; s_ir = 6; s_it = 4'd1; s_rd[0] = 8;
    step("t6_flush_iss", 0);
    clear_stim(); s_rd[0] = 6; s_rd[1] = 8;
    step("t6_after_flush", 1);

    // Random traffic on a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      clear_stim();
      for (int i = 0; i < NRD; i++) s_rd[i] = $urandom_range(0, 7);
      for (int p = 0; p < NWR; p++) begin
        s_we[p] = ($urandom_range(0, 2) == 0);
        s_wa[p] = $urandom_range(0, 7);
        s_wd[p] = $urandom;
        s_wt[p] = TAGW'($urandom_range(0, 3));
      end
      s_ie = $urandom_range(0, 1) == 1;
      s_ir = $urandom_range(0, 7);
      s_it = TAGW'($urandom_range(0, 3));
      s_fl = ($urandom_range(0, 15) == 0);
      step("rand", (n % 25) == 24);
      if (n == 200) reset_mid("rand_reset");
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
